edge_irq_latch: RTL and testbench
=================================

EDGE_IRQ_LATCH -- requirements
Module: edge_irq_latch

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent trigger channels, legal range 1..16.
REQ-002 Parameter FILTER, default 0, number of consecutive stable samples required before a level change is accepted; 0 = unfiltered, legal range 0..15.
REQ-003 Parameter IDW, default $clog2(CHANNELS) with a minimum of 1, width of irq_id.
REQ-004 clk  input  1  system clock; all state updates on the falling edge of clk.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 trigger  input  CHANNELS  raw per-channel event lines, already synchronous to clk.
REQ-007 mode  input  2*CHANNELS  per-channel detect mode, bits [2i+1:2i]: 00 falling, 01 rising, 10 both edges, 11 level-low.
REQ-008 clear  input  CHANNELS  per-channel acknowledge; only its rising edge clears.
REQ-009 enable  input  CHANNELS  per-channel mask for irq and irq_id; it does not gate latching.
REQ-010 pending  output  CHANNELS  sticky per-channel event flags (registered).
REQ-011 irq  output  1  high when any enabled channel is pending.
REQ-012 irq_id  output  IDW  index of the lowest-numbered pending and enabled channel; 0 when irq is low.

Function
REQ-013 Each channel SHALL hold these registers: filtered level filt, previous filtered level hist, clear history clr_q, filter counter cnt (4 bits), and pending bit; one shared primed flag.
REQ-014 With FILTER=0, filt SHALL equal the trigger value sampled at the current edge.
REQ-015 With FILTER=F>0, cnt SHALL increment on each edge where trigger != filt and reset to 0 on any edge where trigger == filt.
REQ-016 With FILTER=F>0, on the edge where trigger != filt and cnt == F-1, filt SHALL take trigger and cnt SHALL return to 0.
REQ-017 With FILTER=F>0, pulses shorter than F samples SHALL never change filt.
REQ-018 A change event SHALL be detected at an edge when the new filt differs from hist; hist SHALL then take the new filt.
REQ-019 Set condition, falling mode: change event with new filt = 0.
REQ-020 Set condition, rising mode: change event with new filt = 1.
REQ-021 Set condition, both mode: any change event.
REQ-022 Set condition, level-low mode: every edge where the new filt = 0.
REQ-023 A clear event SHALL occur on an edge where clear[i] = 1 and clr_q[i] = 0; clr_q SHALL take clear on every edge; a held-high clear SHALL clear only once.
REQ-024 pending[i] update priority: set condition first (pending = 1), else clear event (pending = 0), else hold.
REQ-025 Simultaneous set and clear on the same edge SHALL leave pending = 1.
REQ-026 Latency: with FILTER=0, pending SHALL assert on the first falling clk edge that samples the qualifying trigger level; with FILTER=F, on the F-th consecutive such edge.
REQ-027 irq and irq_id SHALL be combinational from pending & enable, with the lowest index taking priority.
REQ-028 A mode change SHALL take effect at the next edge and SHALL NOT by itself set or clear pending.
REQ-029 Channels SHALL be fully independent; activity on one channel SHALL NOT alter another channel's pending.

Reset
REQ-030 While rst_n = 0: pending = 0, cnt = 0, filt = 1, hist = 1, clr_q = 1, primed = 0; irq = 0 and irq_id = 0.
REQ-031 On the first edge after reset release (primed = 0), filt and hist SHALL load the sampled trigger with no event detected, and primed SHALL be set.
REQ-032 Reset asserted mid-filter-count or mid-event SHALL discard all partial state with no spurious pending afterwards.

Verification
REQ-033 CHANNELS=4, FILTER=0, mode=falling all, enable=F: trigger[2] 1->0 -> pending=0100 on that edge, irq=1, irq_id=2; trigger[2] 0->1 -> no change.
REQ-034 Clear rising edge on channel 2 with clear held high 5 cycles -> pending[2]=0 after the first edge only; a new falling edge while clear is still high re-sets pending[2].
REQ-035 Same edge carries trigger[1] falling and clear[1] rising -> pending[1]=1.
REQ-036 FILTER=3, rising mode: 2-cycle high glitch -> no pending; 3-cycle high -> pending set on the 3rd sampled edge.
REQ-037 pending=1010, enable=0010 -> irq=1, irq_id=1; enable=0000 -> irq=0, irq_id=0, pending still 1010.
REQ-038 Trigger held low through reset release with mode=falling -> no pending; mode=level-low -> pending set from the 2nd edge after release.

Source files
------------

// File: rtl/edge_irq_latch.sv
// edge_irq_latch
// Per-channel edge/level event latch with an optional glitch filter,
// sticky pending flags, a rising-edge acknowledge and a masked,
// lowest-index-first interrupt request. All state moves on the falling
// edge of clk.
module edge_irq_latch #(
  parameter int CHANNELS = 4,
  parameter int FILTER   = 0,
  parameter int IDW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   trigger,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clear,
  input  logic [CHANNELS-1:0]   enable,
  output logic [CHANNELS-1:0]   pending,
  output logic                  irq,
  output logic [IDW-1:0]        irq_id
);

  localparam logic [1:0] MODE_FALL = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_LOW  = 2'b11;

  // Terminal count of the filter counter; unused when FILTER is 0.
  localparam int         FILT_M1 = (FILTER > 0) ? FILTER - 1 : 0;
  localparam logic [3:0] CNT_TC  = FILT_M1[3:0];

  logic [CHANNELS-1:0]      filt;
  logic [CHANNELS-1:0]      hist;
  logic [CHANNELS-1:0]      clr_q;
  logic [CHANNELS-1:0][3:0] cnt;
  logic                     primed;

  logic [CHANNELS-1:0]      filt_nxt;
  logic [CHANNELS-1:0][3:0] cnt_nxt;
  logic [CHANNELS-1:0]      chg;
  logic [CHANNELS-1:0]      set_c;
  logic [CHANNELS-1:0]      clr_ev;
  logic [CHANNELS-1:0]      active;

  // Next filtered level, change detection and per-mode set/clear conditions.
  always_comb begin
    filt_nxt = filt;
    cnt_nxt  = cnt;
    chg      = '0;
    set_c    = '0;
    clr_ev   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (FILTER == 0) begin
        filt_nxt[i] = trigger[i];
      end else if (trigger[i] != filt[i]) begin
        if (cnt[i] == CNT_TC) begin
          filt_nxt[i] = trigger[i];
          cnt_nxt[i]  = 4'd0;
        end else begin
          cnt_nxt[i]  = cnt[i] + 4'd1;
        end
      end else begin
        cnt_nxt[i] = 4'd0;
      end

      chg[i] = filt_nxt[i] ^ hist[i];

      case (mode[2*i +: 2])
        MODE_FALL: set_c[i] = chg[i] & ~filt_nxt[i];
        MODE_RISE: set_c[i] = chg[i] &  filt_nxt[i];
        MODE_BOTH: set_c[i] = chg[i];
        MODE_LOW:  set_c[i] = ~filt_nxt[i];
        default:   set_c[i] = 1'b0;
      endcase

      clr_ev[i] = clear[i] & ~clr_q[i];
    end
  end

  // State registers; the first edge after reset only captures the line
  // levels so that a line sitting at its active level is not seen as an edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt    <= '1;
      hist    <= '1;
      clr_q   <= '1;
      cnt     <= '0;
      pending <= '0;
      primed  <= 1'b0;
    end else begin
      clr_q <= clear;
      if (!primed) begin
        filt   <= trigger;
        hist   <= trigger;
        cnt    <= '0;
        primed <= 1'b1;
      end else begin
        filt    <= filt_nxt;
        hist    <= filt_nxt;
        cnt     <= cnt_nxt;
        pending <= set_c | (pending & ~clr_ev);
      end
    end
  end

  // Masked request and lowest-index priority encode.
  always_comb begin
    active = pending & enable;
    irq    = |active;
    irq_id = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (active[i]) irq_id = IDW'(i);
    end
  end

endmodule

// File: tb/tb_edge_irq_latch.sv
// Bench for edge_irq_latch: an unfiltered and a FILTER=3 instance share
// the same stimulus and are both compared against a run-length reference
// model after every falling edge.
module tb_edge_irq_latch;

  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] trigger;
  logic [2*CH-1:0] mode;
  logic [CH-1:0] clear;
  logic [CH-1:0] enable;

  logic [CH-1:0] pend0, pend1;
  logic          irq0, irq1;
  logic [1:0]    id0, id1;

  int errors = 0;
  int checks = 0;

  // Reference model state: [instance][channel]
  bit m_filt   [2][CH];
  bit m_last   [2][CH];
  bit m_pend   [2][CH];
  bit m_clrp   [2][CH];
  int m_run    [2][CH];
  bit m_primed [2];

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  edge_irq_latch #(.CHANNELS(CH), .FILTER(0)) u_f0 (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .mode(mode),
    .clear(clear), .enable(enable), .pending(pend0), .irq(irq0), .irq_id(id0)
  );

  edge_irq_latch #(.CHANNELS(CH), .FILTER(3)) u_f3 (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .mode(mode),
    .clear(clear), .enable(enable), .pending(pend1), .irq(irq1), .irq_id(id1)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_primed[d] = 1'b0;
      for (int i = 0; i < CH; i++) begin
        m_pend[d][i] = 1'b0;
        m_run[d][i]  = 0;
      end
    end
  endfunction

  // A filtered level follows the line once the line has held its new value
  // for F consecutive samples (F=0 or 1: immediately).
  function automatic void model_step();
    if (!rst_n) return;
    for (int d = 0; d < 2; d++) begin
      int f;
      f = (d == 0) ? 0 : 3;
      for (int i = 0; i < CH; i++) begin
        bit t, nf, setc, clrc;
        t = trigger[i];
        if (!m_primed[d]) begin
          m_filt[d][i] = t;
          m_last[d][i] = t;
          m_run[d][i]  = 1;
          m_clrp[d][i] = clear[i];
          continue;
        end
        m_run[d][i]  = (t == m_last[d][i]) ? m_run[d][i] + 1 : 1;
        m_last[d][i] = t;
        nf = m_filt[d][i];
        if (t != m_filt[d][i] && m_run[d][i] >= f) nf = t;
        case (mode[2*i +: 2])
          2'b00:   setc = (nf != m_filt[d][i]) && !nf;
          2'b01:   setc = (nf != m_filt[d][i]) && nf;
          2'b10:   setc = (nf != m_filt[d][i]);
          default: setc = !nf;
        endcase
        clrc = clear[i] && !m_clrp[d][i];
        if (setc)      m_pend[d][i] = 1'b1;
        else if (clrc) m_pend[d][i] = 1'b0;
        m_clrp[d][i] = clear[i];
        m_filt[d][i] = nf;
      end
      m_primed[d] = 1'b1;
    end
  endfunction

  function automatic int exp_pend(input int d);
    int v = 0;
    for (int i = 0; i < CH; i++) if (m_pend[d][i]) v |= (1 << i);
    return v;
  endfunction

  function automatic int exp_irq(input int d);
    return ((exp_pend(d) & int'(enable)) != 0) ? 1 : 0;
  endfunction

  function automatic int exp_id(input int d);
    int a = exp_pend(d) & int'(enable);
    int id = 0;
    for (int i = CH - 1; i >= 0; i--) if (a[i]) id = i;
    return id;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".pend0"}, int'(pend0), exp_pend(0));
    check({tag, ".irq0"},  int'(irq0),  exp_irq(0));
    check({tag, ".id0"},   int'(id0),   exp_id(0));
    check({tag, ".pend1"}, int'(pend1), exp_pend(1));
    check({tag, ".irq1"},  int'(irq1),  exp_irq(1));
    check({tag, ".id1"},   int'(id1),   exp_id(1));
  endtask

  // One falling edge, then compare both instances against the model.
  task automatic cyc(input string tag);
    @(negedge clk);
    #1;
    model_step();
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst");
    check("rst.pend0_zero", int'(pend0), 0);
    check("rst.irq1_zero",  int'(irq1),  0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    trigger = '1;
    mode    = '0;
    clear   = '0;
    enable  = '1;
    model_reset();

    // Falling-mode basics, all channels enabled.
    do_reset();
    release_reset();
    cyc("prime");
    cyc("idle");
    trigger = 4'b1011;
    cyc("fall2");
    check("fall2.pend", int'(pend0), 4);
    check("fall2.irq",  int'(irq0),  1);
    check("fall2.id",   int'(id0),   2);
    trigger = 4'b1111;
    cyc("rise2");
    check("rise2.pend", int'(pend0), 4);

    // Held clear acknowledges once; a new edge under held clear re-sets.
    clear = 4'b0100;
    cyc("clr_a");
    check("clr_a.pend", int'(pend0), 0);
    cyc("clr_b");
    trigger = 4'b1011;
    cyc("clr_c");
    check("clr_c.pend", int'(pend0), 4);
    trigger = 4'b1111;
    cyc("clr_d");
    cyc("clr_e");
    check("clr_e.pend", int'(pend0), 4);
    clear = '0;
    cyc("clr_f");

    // Set and clear on the same edge: set wins.
    trigger = 4'b1101;
    clear   = 4'b0010;
    cyc("setclr");
    check("setclr.pend", int'(pend0), 6);
    trigger = 4'b1111;
    clear   = '0;
    cyc("setclr_b");
    clear = 4'b1111;
    cyc("clr_all");
    check("clr_all.pend", int'(pend0), 0);
    clear = '0;
    cyc("clr_all_b");

    // Enable masks irq/irq_id only.
    trigger = 4'b0101;
    cyc("mask_a");
    check("mask_a.pend", int'(pend0), 10);
    enable = 4'b0010;
    cyc("mask_b");
    check("mask_b.irq", int'(irq0), 1);
    check("mask_b.id",  int'(id0),  1);
    enable = 4'b0000;
    cyc("mask_c");
    check("mask_c.irq",  int'(irq0),  0);
    check("mask_c.id",   int'(id0),   0);
    check("mask_c.pend", int'(pend0), 10);
    enable = 4'b1111;

    // Glitch filter, rising mode.
    do_reset();
    trigger = '0;
    mode    = 8'h55;
    clear   = '0;
    release_reset();
    cyc("f_prime");
    cyc("f_idle");
    trigger = 4'b0001;
    cyc("glitch_a");
    cyc("glitch_b");
    trigger = 4'b0000;
    cyc("glitch_c");
    cyc("glitch_d");
    check("glitch.pend1", int'(pend1), 0);
    trigger = 4'b0001;
    cyc("pulse_a");
    cyc("pulse_b");
    check("pulse_b.pend1", int'(pend1), 0);
    cyc("pulse_c");
    check("pulse_c.pend1", int'(pend1), 1);

    // Line low through reset release.
    do_reset();
    trigger = '0;
    mode    = 8'h00;
    release_reset();
    cyc("low_fall_a");
    cyc("low_fall_b");
    check("low_fall.pend0", int'(pend0), 0);
    check("low_fall.pend1", int'(pend1), 0);
    do_reset();
    mode = 8'hFF;
    release_reset();
    cyc("low_lvl_a");
    check("low_lvl_a.pend0", int'(pend0), 0);
    cyc("low_lvl_b");
    check("low_lvl_b.pend0", int'(pend0), 15);
    check("low_lvl_b.pend1", int'(pend1), 15);

    // Randomized traffic, including resets mid-filter and mid-event.
    mode   = 8'h00;
    enable = '1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 3) == 0) trigger[i] = ~trigger[i];
        if ($urandom_range(0, 5) == 0) clear[i]   = ~clear[i];
      end
      if ($urandom_range(0, 49) == 0) mode   = 8'($urandom);
      if ($urandom_range(0, 19) == 0) enable = 4'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        trigger = 4'($urandom);
        release_reset();
      end
      cyc("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
